// File: rtl/apb2axi_pkg.sv
// Shared definitions for the APB-side response reader: entry layout, register map, STATUS fields.
package apb2axi_pkg;

    localparam int unsigned RSP_DATA_W = 32;
    localparam int unsigned RSP_ID_W   = 4;
    localparam int unsigned POP_CNT_W  = 8;
    localparam int unsigned WAIT_W     = 8;

    // One response entry as carried by the response FIFO, MSB first.
    typedef struct packed {
        logic [RSP_ID_W-1:0]   id;
        logic [1:0]            resp;
        logic                  last;
        logic [RSP_DATA_W-1:0] data;
    } rsp_entry_t;

    // Register byte offsets.
    localparam int unsigned REG_STATUS = 32'h000;
    localparam int unsigned REG_DATA   = 32'h004;
    localparam int unsigned REG_CTRL   = 32'h008;

    // STATUS bit positions.
    localparam int unsigned ST_VALID_BIT  = 0;
    localparam int unsigned ST_TMO_BIT    = 1;
    localparam int unsigned ST_ID_LSB     = 4;
    localparam int unsigned ST_RESP_LSB   = 8;
    localparam int unsigned ST_LAST_BIT   = 10;
    localparam int unsigned ST_POPCNT_LSB = 16;

    // APB transfer phase tracking.
    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_e;

    // Assemble the STATUS word; entry fields read as zero while the holding register is empty.
    function automatic logic [31:0] pack_status(
        input logic                 hold_valid,
        input logic                 timeout_sticky,
        input logic [RSP_ID_W-1:0]  id,
        input logic [1:0]           resp,
        input logic                 last,
        input logic [POP_CNT_W-1:0] pop_cnt
    );
        logic [31:0] s;
        s = '0;
        s[ST_VALID_BIT] = hold_valid;
        s[ST_TMO_BIT]   = timeout_sticky;
        if (hold_valid) begin
            s[ST_ID_LSB +: RSP_ID_W] = id;
            s[ST_RESP_LSB +: 2]      = resp;
            s[ST_LAST_BIT]           = last;
        end
        s[ST_POPCNT_LSB +: POP_CNT_W] = pop_cnt;
        return s;
    endfunction

endpackage

// File: rtl/apb2axi_rsp_reader.sv
// APB-side reader of the response FIFO: one-entry holding register exposed through STATUS/DATA/CTRL.
module apb2axi_rsp_reader
    import apb2axi_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     pclk,
    input  logic                     presetn,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [ADDR_W-1:0]        paddr,
    input  logic [DATA_W-1:0]        pwdata,
    output logic [DATA_W-1:0]        prdata,
    output logic                     pready,
    output logic                     pslverr,
    input  logic                     fifo_valid,
    input  logic [DATA_W+ID_W+2:0]   fifo_data,
    output logic                     fifo_ready
);

    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(REG_STATUS);
    localparam logic [ADDR_W-1:0] A_DATA   = ADDR_W'(REG_DATA);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(REG_CTRL);

    apb_state_e              state_q, state_d;
    rsp_entry_t              hold_q, hold_d;
    logic                    hold_valid_q, hold_valid_d;
    logic                    sticky_q, sticky_d;
    logic [POP_CNT_W-1:0]    pop_cnt_q, pop_cnt_d;
    logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;

    logic                    access_c;
    logic                    fill_c;
    logic [ADDR_W-1:0]       reg_addr_c;
    logic [31:0]             status_c;
    logic                    unused_c;

    // state_q records the previous bus phase; an access phase is only honoured after a seen setup.
    assign access_c   = psel && penable && (state_q != APB_IDLE);
    assign reg_addr_c = {paddr[ADDR_W-1:2], 2'b00};
    assign fifo_ready = !hold_valid_q;
    assign fill_c     = fifo_valid && !hold_valid_q;
    assign status_c   = pack_status(hold_valid_q, sticky_q, hold_q.id, hold_q.resp,
                                    hold_q.last, pop_cnt_q);
    assign unused_c   = ^{pwdata[DATA_W-1:2], paddr[1:0]};

    // Register decode, wait/timeout handling, counters, holding-register fill and phase tracking.
    always_comb begin
        prdata       = '0;
        pready       = 1'b0;
        pslverr      = 1'b0;
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        sticky_d     = sticky_q;
        pop_cnt_d    = pop_cnt_q;
        wait_cnt_d   = '0;

        if (access_c) begin
            pready = 1'b1;
            if (reg_addr_c == A_STATUS) begin
                if (pwrite) pslverr = 1'b1;
                else        prdata  = DATA_W'(status_c);
            end else if (reg_addr_c == A_DATA) begin
                if (pwrite) begin
                    pslverr = 1'b1;
                end else if (hold_valid_q) begin
                    // An entry present (even one that arrived while waiting) wins over the timeout.
                    prdata       = DATA_W'(hold_q.data);
                    hold_valid_d = 1'b0;
                    pop_cnt_d    = pop_cnt_q + POP_CNT_W'(1);
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
                    pslverr  = 1'b1;
                    sticky_d = 1'b1;
                end else begin
                    pready     = 1'b0;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end else if (reg_addr_c == A_CTRL) begin
                if (pwrite) begin
                    if (pwdata[0]) sticky_d  = 1'b0;
                    if (pwdata[1]) pop_cnt_d = '0;
                end
            end else begin
                pslverr = 1'b1;
            end
        end

        // Pop and fill are mutually exclusive: a fill needs the register empty, a pop needs it full.
        if (fill_c) begin
            hold_d.data  = RSP_DATA_W'(fifo_data[DATA_W-1:0]);
            hold_d.last  = fifo_data[DATA_W];
            hold_d.resp  = fifo_data[DATA_W+2 -: 2];
            hold_d.id    = RSP_ID_W'(fifo_data[DATA_W+3 +: ID_W]);
            hold_valid_d = 1'b1;
        end

        if (access_c && !pready) state_d = APB_ACCESS;
        else if (access_c)       state_d = APB_IDLE;
        else if (psel && !penable) state_d = APB_SETUP;
        else                     state_d = APB_IDLE;
    end

    // State, holding register and counters; reset discards the entry and abandons any transfer.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q      <= APB_IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            sticky_q     <= 1'b0;
            pop_cnt_q    <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            sticky_q     <= sticky_d;
            pop_cnt_q    <= pop_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_apb2axi_rsp_reader.sv
// Bench for apb2axi_rsp_reader: APB master, response-FIFO model and a transaction-level reference.
module tb_apb2axi_rsp_reader;

    localparam int unsigned DW  = 32;
    localparam int unsigned IW  = 4;
    localparam int unsigned AW  = 12;
    localparam int unsigned TMO = 16;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic          fifo_valid = 1'b0;
    logic [38:0]   fifo_data = '0;
    logic          fifo_ready;

    apb2axi_rsp_reader #(
        .DATA_W (DW),
        .ID_W   (IW),
        .ADDR_W (AW),
        .TIMEOUT(TMO)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .fifo_valid(fifo_valid),
        .fifo_data (fifo_data),
        .fifo_ready(fifo_ready)
    );

    always #5 pclk = ~pclk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: pending FIFO contents, the one held entry, sticky flag and pop count.
    logic [38:0] fq[$];
    logic [38:0] m_hold = '0;
    bit          m_hv = 0;
    bit          m_sticky = 0;
    logic [7:0]  m_pop = '0;
    bit          pend_pop, pend_tmo, pend_clr_tmo, pend_clr_pop;
    bit          in_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [38:0] mk(input logic [3:0] id, input logic [1:0] resp,
                                       input logic last, input logic [31:0] data);
        return {id, resp, last, data};
    endfunction

    function automatic logic [38:0] rand_ent();
        return mk(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom());
    endfunction

    function automatic logic [31:0] m_status();
        logic [3:0] id;
        logic [1:0] resp;
        logic       last;
        id   = m_hv ? m_hold[38:35] : 4'h0;
        resp = m_hv ? m_hold[34:33] : 2'h0;
        last = m_hv ? m_hold[32]    : 1'b0;
        return {8'h00, m_pop, 5'h00, last, resp, id, 2'b00, m_sticky, m_hv};
    endfunction

    task automatic drive_fifo();
        fifo_valid = (fq.size() > 0);
        fifo_data  = (fq.size() > 0) ? fq[0] : 39'h0;
    endtask

    task automatic push(input logic [38:0] e);
        fq.push_back(e);
        drive_fifo();
    endtask

    task automatic reset_model();
        m_hv = 0; m_sticky = 0; m_pop = '0;
        pend_pop = 0; pend_tmo = 0; pend_clr_tmo = 0; pend_clr_pop = 0;
    endtask

    // One clock: check idle outputs and fifo_ready, then advance the model across the edge.
    task automatic tick();
        bit hs;
        #1;
        chk("fifo_ready", 32'(fifo_ready), 32'(!m_hv));
        if (!in_acc) begin
            chk("idle_pready", 32'(pready), 32'h0);
            chk("idle_pslverr", 32'(pslverr), 32'h0);
            chk("idle_prdata", prdata, 32'h0);
        end
        hs = presetn && (fq.size() > 0) && !m_hv;
        @(posedge pclk);
        if (presetn) begin
            if (pend_pop) begin m_hv = 0; m_pop++; end
            if (pend_tmo) m_sticky = 1;
            if (pend_clr_tmo) m_sticky = 0;
            if (pend_clr_pop) m_pop = '0;
            if (hs) begin m_hold = fq.pop_front(); m_hv = 1; end
        end
        pend_pop = 0; pend_tmo = 0; pend_clr_tmo = 0; pend_clr_pop = 0;
        @(negedge pclk);
        drive_fifo();
    endtask

    // Full APB transfer; every access cycle is compared against the reference rules.
    task automatic apb_xfer(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                            input int push_at, input logic [38:0] push_ent,
                            output logic [31:0] rdata, output logic err, output int waits);
        logic [AW-1:0] off;
        bit            erdy, eerr, done;
        logic [31:0]   erd;
        int            n;
        off = {addr[AW-1:2], 2'b00};
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        in_acc = 0;
        tick();
        penable = 1'b1;
        in_acc = 1;
        waits = 0; n = 0; done = 0; rdata = '0; err = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            #1;
            erdy = 1; eerr = 0; erd = '0;
            case (off)
                12'h000: if (wr) eerr = 1; else erd = m_status();
                12'h004: begin
                    if (wr) eerr = 1;
                    else if (m_hv) begin erd = m_hold[31:0]; pend_pop = 1; end
                    else if (n == TMO) begin eerr = 1; pend_tmo = 1; end
                    else erdy = 0;
                end
                12'h008: if (wr) begin pend_clr_tmo = wdata[0]; pend_clr_pop = wdata[1]; end
                default: eerr = 1;
            endcase
            chk("pready", 32'(pready), 32'(erdy));
            chk("pslverr", 32'(pslverr), 32'(eerr));
            chk("prdata", prdata, erd);
            if (!erdy) n++;
            if (pready) begin
                done = 1; rdata = prdata; err = pslverr;
            end else begin
                waits++;
                if (waits == push_at) push(push_ent);
            end
            tick();
        end
        if (!done) chk("xfer_bound", 32'h0, 32'h1);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        in_acc = 0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          w;
    logic [AW-1:0] bad_addr [4] = '{12'h00C, 12'h010, 12'h800, 12'hFFC};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_model();
        drive_fifo();
        @(negedge pclk);
        repeat (3) tick();
        presetn = 1'b1;
        tick();

        // Reset state read.
        apb_xfer(0, 12'h000, 0, -1, 0, rd, er, w);
        chk("lit_rst_status", rd, 32'h0000_0000);
        chk("lit_rst_err", 32'(er), 32'h0);
        chk("lit_rst_waits", 32'(w), 32'h0);

        // Single entry: STATUS, DATA, STATUS.
        push(mk(4'd3, 2'd0, 1'b1, 32'hCAFE_F00D));
        tick();
        apb_xfer(0, 12'h000, 0, -1, 0, rd, er, w);
        chk("lit_status_loaded", rd, 32'h0000_0431);
        apb_xfer(0, 12'h004, 0, -1, 0, rd, er, w);
        chk("lit_data", rd, 32'hCAFE_F00D);
        chk("lit_data_err", 32'(er), 32'h0);
        apb_xfer(0, 12'h000, 0, -1, 0, rd, er, w);
        chk("lit_status_popped", rd, 32'h0001_0000);

        // Four queued entries, back-to-back zero-wait reads.
        apb_xfer(1, 12'h008, 32'h2, -1, 0, rd, er, w);
        for (int i = 0; i < 4; i++) push(mk(4'(i), 2'd1, 1'b0, 32'h1111_0000 + 32'(i)));
        tick();
        for (int i = 0; i < 4; i++) begin
            apb_xfer(0, 12'h004, 0, -1, 0, rd, er, w);
            chk("lit_b2b_data", rd, 32'h1111_0000 + 32'(i));
            chk("lit_b2b_waits", 32'(w), 32'h0);
        end
        apb_xfer(0, 12'h000, 0, -1, 0, rd, er, w);
        chk("lit_b2b_status", rd, 32'h0004_0000);

        // Empty read times out after TIMEOUT wait states; CTRL clears the sticky flag.
        apb_xfer(0, 12'h004, 0, -1, 0, rd, er, w);
        chk("lit_tmo_waits", 32'(w), 32'(TMO));
        chk("lit_tmo_err", 32'(er), 32'h1);
        chk("lit_tmo_rdata", rd, 32'h0);
        apb_xfer(0, 12'h000, 0, -1, 0, rd, er, w);
        chk("lit_tmo_status", rd, 32'h0004_0002);
        apb_xfer(1, 12'h008, 32'h1, -1, 0, rd, er, w);
        apb_xfer(0, 12'h000, 0, -1, 0, rd, er, w);
        chk("lit_tmo_cleared", rd, 32'h0004_0000);

        // Empty read rescued by a push during the wait.
        apb_xfer(0, 12'h004, 0, 5, mk(4'd5, 2'd2, 1'b0, 32'h5A5A_0005), rd, er, w);
        chk("lit_late_data", rd, 32'h5A5A_0005);
        chk("lit_late_err", 32'(er), 32'h0);
        chk("lit_late_waits", 32'(w), 32'h5);
        apb_xfer(0, 12'h000, 0, -1, 0, rd, er, w);
        chk("lit_late_status", rd, 32'h0005_0000);

        // pop_cnt wraps after 256 pops.
        apb_xfer(1, 12'h008, 32'h2, -1, 0, rd, er, w);
        for (int i = 0; i < 257; i++) begin
            push(rand_ent());
            apb_xfer(0, 12'h004, 0, -1, 0, rd, er, w);
        end
        apb_xfer(0, 12'h000, 0, -1, 0, rd, er, w);
        chk("lit_wrap_status", rd, 32'h0001_0000);

        // Reset in the middle of a DATA access with an entry held.
        push(mk(4'd9, 2'd3, 1'b1, 32'hDEAD_BEEF));
        tick();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h004;
        tick();
        penable = 1'b1;
        #2;
        presetn = 1'b0;
        reset_model();
        #1;
        chk("lit_inrst_pready", 32'(pready), 32'h0);
        chk("lit_inrst_fifo_ready", 32'(fifo_ready), 32'h1);
        tick();
        psel = 1'b0; penable = 1'b0;
        tick();
        presetn = 1'b1;
        tick();
        apb_xfer(0, 12'h000, 0, -1, 0, rd, er, w);
        chk("lit_postrst_status", rd, 32'h0);
        apb_xfer(1, 12'h004, 32'h3, -1, 0, rd, er, w);
        chk("lit_wr_data_err", 32'(er), 32'h1);
        apb_xfer(1, 12'h000, 32'h3, -1, 0, rd, er, w);
        chk("lit_wr_status_err", 32'(er), 32'h1);
        apb_xfer(0, 12'h00C, 0, -1, 0, rd, er, w);
        chk("lit_unmapped_err", 32'(er), 32'h1);
        chk("lit_unmapped_rdata", rd, 32'h0);

        // Randomized traffic against the reference.
        for (int it = 0; it < 400; it++) begin
            int r;
            logic [AW-1:0] lo;
            lo = AW'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 35) begin
                int k;
                k = $urandom_range(1, 2);
                for (int j = 0; j < k; j++) push(rand_ent());
            end
            r = $urandom_range(0, 99);
            if (r < 35)
                apb_xfer(0, 12'h004 | lo, 0, ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 20)) : -1,
                         rand_ent(), rd, er, w);
            else if (r < 60) apb_xfer(0, 12'h000 | lo, 0, -1, 0, rd, er, w);
            else if (r < 68) apb_xfer(1, 12'h008 | lo, $urandom(), -1, 0, rd, er, w);
            else if (r < 72) apb_xfer(0, 12'h008 | lo, 0, -1, 0, rd, er, w);
            else if (r < 80) apb_xfer(1, ($urandom_range(0, 1) != 0) ? 12'h004 : 12'h000, $urandom(),
                                      -1, 0, rd, er, w);
            else if (r < 88) apb_xfer(1'($urandom_range(0, 1)), bad_addr[$urandom_range(0, 3)],
                                      $urandom(), -1, 0, rd, er, w);
            else begin
                int k;
                k = $urandom_range(1, 3);
                repeat (k) tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/apb2axi_rsp_reader.md
# apb2axi_rsp_reader

APB-clock-domain consumer of the bridge's read-response path. It drains response entries (id, resp, last, data) from the read side of the response async FIFO into a one-entry holding register. It exposes each entry to software through a small APB register file, and popping DATA advances to the next entry. It is the reader counterpart to the AXI-side block that writes responses into that FIFO.

## Interface
Parameters:
- DATA_W, 32, response data width; equals APB data width.
- ID_W, 4, AXI ID width; max 4.
- ADDR_W, 12, APB address width.
- TIMEOUT, 16, maximum wait states on an empty DATA read; range 1..255.

Ports (one clock; reset is asynchronous and active-low):
- pclk  in  1  APB/response clock.
- presetn  in  1  async active-low reset.
- psel, penable, pwrite  in  1 each  APB control.
- paddr  in  ADDR_W  byte address; bits [1:0] ignored.
- pwdata  in  DATA_W  write data.
- prdata  out  DATA_W  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error.
- fifo_valid  in  1  response entry available.
- fifo_data  in  DATA_W+ID_W+3  entry {id, resp[1:0], last, data}, MSB first.
- fifo_ready  out  1  holding register empty; accepts entry.

## Operation
- Fill:
  - fifo_ready = !hold_valid, driven directly from the register.
  - A handshake (fifo_valid && fifo_ready) at cycle T captures fifo_data; hold_valid=1 from T+1.
- Register map:
  - 0x00 STATUS (RO):
    - bit0 hold_valid.
    - bit1 timeout_sticky.
    - [7:4] id, [9:8] resp, bit10 last; these fields are zero when hold_valid=0.
    - [23:16] pop_cnt.
  - 0x04 DATA (RO, pop-on-read): returns hold data, clears hold_valid, pop_cnt+1.
  - 0x08 CTRL (WO): bit0=1 clears timeout_sticky; bit1=1 clears pop_cnt; reads return 0, pslverr=0.
- pop_cnt: 8-bit, wraps 255->0.
  - A clear and a pop in the same cycle yield 0; clear wins.
- DATA read with hold_valid=0:
  - Insert wait states (pready=0) and count them in wait_cnt.
  - If an entry loads before wait_cnt reaches TIMEOUT, complete normally in the cycle hold_valid is seen.
  - Otherwise complete with pslverr=1, prdata=0, no pop, and set timeout_sticky.
- Errors:
  - Write to STATUS or DATA: pslverr=1, no side effect.
  - Any access to an unmapped offset: pslverr=1, prdata=0.
- Reset mid-operation:
  - Holding entry discarded; wait_cnt, pop_cnt and timeout_sticky cleared.
  - Any APB access in progress is abandoned.

## Timing
- APB FSM: IDLE -> SETUP (psel & !penable) -> ACCESS (psel & penable).
  - ACCESS holds while pready=0 and returns to IDLE/SETUP on completion.
  - All registers except DATA complete in ACCESS with zero wait states.
- prdata, pready and pslverr are combinational from state and paddr during ACCESS, and are 0 outside ACCESS.
- Values in reset: prdata=0, pready=0, pslverr=0, fifo_ready=1.
- Pop timing:
  - A DATA pop completes at T; hold_valid=0 and fifo_ready=1 at T+1; reload at T+1; hold_valid=1 at T+2.
  - Back-to-back APB DATA reads (SETUP T+1, ACCESS T+2) are therefore zero-wait while the FIFO is non-empty.
- DATA read that waits:
  - wait_cnt increments each ACCESS cycle with pready=0.
  - The timeout completion occurs in the ACCESS cycle where wait_cnt==TIMEOUT, giving TIMEOUT wait states.
  - wait_cnt clears on completion.
- Simultaneous pop and fill in the same cycle cannot occur, because fifo_ready=0 while loaded.
- A STATUS read in the same cycle an entry loads returns pre-load values.

## Structure
- Shared package apb2axi_pkg holds:
  - the rsp_entry_t packed struct (id, resp, last, data);
  - the register offset constants STATUS/DATA/CTRL;
  - the STATUS bit-position constants.
- No sub-module: the holding register, the APB FSM and the counters are inline (~200 lines).

## Test plan
- Reset then STATUS read -> prdata=0x0000_0000, pslverr=0, zero wait; fifo_ready=1.
- Push {id=3, resp=0, last=1, data=0xCAFE_F00D}, read STATUS then DATA -> STATUS=0x0000_0431, DATA=0xCAFE_F00D; after the pop, STATUS=0x0001_0000.
- FIFO holds 4 entries; 4 back-to-back DATA reads -> all complete with no wait states, data in order, pop_cnt=4.
- DATA read on an empty FIFO with TIMEOUT=16, no push -> 16 wait states, pslverr=1, prdata=0, STATUS bit1=1; CTRL write 0x1 clears it.
- DATA read on an empty FIFO, push issued at wait cycle 5 -> completes with the pushed data, pslverr=0, timeout_sticky stays 0.
- Entry loaded, presetn pulsed low mid-ACCESS of a DATA read -> after release STATUS=0, fifo_ready=1; write to 0x04 -> pslverr=1.
